// File: rtl/ttc_trig_pkg.sv
// Shared definitions for the TTC trigger-info word: field positions, widths,
// trigger-type codes and reader FSM state indices.
package ttc_trig_pkg;

    localparam int WORD_W      = 128;

    localparam int TS_W        = 44;
    localparam int TRIGNUM_W   = 24;
    localparam int EVTCNT_W    = 24;
    localparam int TYPE_W      = 5;
    localparam int XADC_W      = 4;
    localparam int RSVD_W      = 26;

    localparam int TS_LSB      = 0;
    localparam int TS_MSB      = 43;
    localparam int TRIGNUM_LSB = 44;
    localparam int TRIGNUM_MSB = 67;
    localparam int EVTCNT_LSB  = 68;
    localparam int EVTCNT_MSB  = 91;
    localparam int TYPE_LSB    = 92;
    localparam int TYPE_MSB    = 96;
    localparam int EMPTY_BIT   = 97;
    localparam int XADC_LSB    = 98;
    localparam int XADC_MSB    = 101;
    localparam int RSVD_LSB    = 102;
    localparam int RSVD_MSB    = 127;

    localparam logic [TYPE_W-1:0] TRIG_TYPE_ASYNC = 5'b00111;

    localparam int ST_W             = 3;
    localparam int ST_IDLE_IDX      = 0;
    localparam int ST_OFFER_IDX     = 1;
    localparam int ST_WAIT_DONE_IDX = 2;

    typedef struct packed {
        logic [XADC_W-1:0]    xadc;
        logic                 empty;
        logic [TYPE_W-1:0]    trig_type;
        logic [EVTCNT_W-1:0]  event_cnt;
        logic [TRIGNUM_W-1:0] trig_num;
        logic [TS_W-1:0]      timestamp;
    } trig_info_t;

    // 24-bit continuity counters wrap 0xFFFFFF -> 0x000000.
    function automatic logic [23:0] next_count(input logic [23:0] v);
        return v + 24'd1;
    endfunction

endpackage

// File: rtl/ttc_trigger_info_reader_if.sv
// FIFO read port and event-descriptor handshake of the trigger-info reader.
// slave = the reader, master = FIFO plus command manager.
interface ttc_trigger_info_reader_if;
    import ttc_trig_pkg::*;

    logic                 fifo_valid;
    logic [WORD_W-1:0]    fifo_data;
    logic                 fifo_ready;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [TRIGNUM_W-1:0] evt_trig_num;
    logic [EVTCNT_W-1:0]  evt_event_cnt;
    logic [TYPE_W-1:0]    evt_trig_type;
    logic                 evt_empty;
    logic [XADC_W-1:0]    evt_xadc_alarms;
    logic [TS_W-1:0]      evt_timestamp;
    logic                 readout_done;

    modport master (
        output fifo_valid, fifo_data, evt_ready, readout_done,
        input  fifo_ready, evt_valid, evt_trig_num, evt_event_cnt,
               evt_trig_type, evt_empty, evt_xadc_alarms, evt_timestamp
    );

    modport slave (
        input  fifo_valid, fifo_data, evt_ready, readout_done,
        output fifo_ready, evt_valid, evt_trig_num, evt_event_cnt,
               evt_trig_type, evt_empty, evt_xadc_alarms, evt_timestamp
    );

endinterface

// File: rtl/ttc_trig_word_unpack.sv
// Combinational split of a 128-bit trigger-info word into its fields, plus a
// flag for any non-zero reserved bit.
module ttc_trig_word_unpack
    import ttc_trig_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output trig_info_t        info,
    output logic              rsvd_err
);

    always_comb begin
        info.timestamp = word[TS_MSB:TS_LSB];
        info.trig_num  = word[TRIGNUM_MSB:TRIGNUM_LSB];
        info.event_cnt = word[EVTCNT_MSB:EVTCNT_LSB];
        info.trig_type = word[TYPE_MSB:TYPE_LSB];
        info.empty     = word[EMPTY_BIT];
        info.xadc      = word[XADC_MSB:XADC_LSB];
        rsvd_err       = |word[RSVD_MSB:RSVD_LSB];
    end

endmodule

// File: rtl/ttc_trigger_info_reader.sv
// Pops TTC trigger-info words, checks continuity, offers one event at a time.
// Optional: TRIG_TIMESTAMP_CHECK_EN adds a monotonic timestamp check.
module ttc_trigger_info_reader
    import ttc_trig_pkg::*;
#(
    parameter logic [23:0] DONE_TIMEOUT = 24'd4000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   reset_trig_num,
    ttc_trigger_info_reader_if.slave bus,
    output logic [ST_W-1:0]        state,
    output logic [23:0]            events_read,
    output logic [23:0]            empty_events,
    output logic                   error_seq,
    output logic                   error_format,
    output logic                   error_timeout
`ifdef TRIG_TIMESTAMP_CHECK_EN
    ,
    output logic                   error_timestamp
`endif
);

    localparam logic [ST_W-1:0] S_IDLE      = ST_W'(1 << ST_IDLE_IDX);
    localparam logic [ST_W-1:0] S_OFFER     = ST_W'(1 << ST_OFFER_IDX);
    localparam logic [ST_W-1:0] S_WAIT_DONE = ST_W'(1 << ST_WAIT_DONE_IDX);

    trig_info_t           word_info;
    logic                 word_rsvd_err;
    logic                 pop;

    logic [ST_W-1:0]      state_q, state_d;
    trig_info_t           evt_q, evt_d;
    logic [23:0]          events_read_q, events_read_d;
    logic [23:0]          empty_events_q, empty_events_d;
    logic [TRIGNUM_W-1:0] exp_trig_q, exp_trig_d;
    logic [EVTCNT_W-1:0]  exp_cnt_q, exp_cnt_d;
    logic                 error_seq_q, error_seq_d;
    logic                 error_format_q, error_format_d;
    logic                 error_timeout_q, error_timeout_d;
    logic [23:0]          to_cnt_q, to_cnt_d;
`ifdef TRIG_TIMESTAMP_CHECK_EN
    logic [TS_W-1:0]      prev_ts_q, prev_ts_d;
    logic                 ts_armed_q, ts_armed_d;
    logic                 error_ts_q, error_ts_d;
`endif

    ttc_trig_word_unpack u_unpack (
        .word     (bus.fifo_data),
        .info     (word_info),
        .rsvd_err (word_rsvd_err)
    );

    // Pop is gated by reset so an aborted event never leaves a pop behind.
    assign pop = reset_n && (state_q == S_IDLE) && bus.fifo_valid;

    always_comb begin
        state_d         = state_q;
        evt_d           = evt_q;
        events_read_d   = events_read_q;
        empty_events_d  = empty_events_q;
        exp_trig_d      = exp_trig_q;
        exp_cnt_d       = exp_cnt_q;
        error_seq_d     = error_seq_q;
        error_format_d  = error_format_q;
        error_timeout_d = error_timeout_q;
        to_cnt_d        = 24'd0;
`ifdef TRIG_TIMESTAMP_CHECK_EN
        prev_ts_d       = prev_ts_q;
        ts_armed_d      = ts_armed_q;
        error_ts_d      = error_ts_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d       = S_OFFER;
                    evt_d         = word_info;
                    events_read_d = next_count(events_read_q);
                    if (word_info.empty) begin
                        empty_events_d = next_count(empty_events_q);
                    end
                    if (word_rsvd_err) begin
                        error_format_d = 1'b1;
                    end
                    if (!reset_trig_num) begin
                        if (word_info.trig_num != exp_trig_q) begin
                            error_seq_d = 1'b1;
                        end
                        exp_trig_d = next_count(word_info.trig_num);
                        // Empty events carry no meaningful accepted-event count.
                        if (!word_info.empty) begin
                            if (word_info.event_cnt != exp_cnt_q) begin
                                error_seq_d = 1'b1;
                            end
                            exp_cnt_d = next_count(word_info.event_cnt);
                        end
                    end
`ifdef TRIG_TIMESTAMP_CHECK_EN
                    if (!reset_trig_num && ts_armed_q &&
                        (word_info.timestamp <= prev_ts_q)) begin
                        error_ts_d = 1'b1;
                    end
                    prev_ts_d  = word_info.timestamp;
                    ts_armed_d = 1'b1;
`endif
                end
            end
            S_OFFER: begin
                if (bus.evt_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.readout_done) begin
                    state_d = S_IDLE;
                end else if ((DONE_TIMEOUT != 24'd0) &&
                             (to_cnt_q == DONE_TIMEOUT - 24'd1)) begin
                    error_timeout_d = 1'b1;
                    state_d         = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Channel B trigger-number reset overrides whatever the pop computed.
        if (reset_trig_num) begin
            exp_trig_d = 24'd1;
            exp_cnt_d  = 24'd1;
`ifdef TRIG_TIMESTAMP_CHECK_EN
            ts_armed_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            evt_q           <= '0;
            events_read_q   <= 24'd0;
            empty_events_q  <= 24'd0;
            exp_trig_q      <= 24'd1;
            exp_cnt_q       <= 24'd1;
            error_seq_q     <= 1'b0;
            error_format_q  <= 1'b0;
            error_timeout_q <= 1'b0;
            to_cnt_q        <= 24'd0;
`ifdef TRIG_TIMESTAMP_CHECK_EN
            prev_ts_q       <= '0;
            ts_armed_q      <= 1'b0;
            error_ts_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            evt_q           <= evt_d;
            events_read_q   <= events_read_d;
            empty_events_q  <= empty_events_d;
            exp_trig_q      <= exp_trig_d;
            exp_cnt_q       <= exp_cnt_d;
            error_seq_q     <= error_seq_d;
            error_format_q  <= error_format_d;
            error_timeout_q <= error_timeout_d;
            to_cnt_q        <= to_cnt_d;
`ifdef TRIG_TIMESTAMP_CHECK_EN
            prev_ts_q       <= prev_ts_d;
            ts_armed_q      <= ts_armed_d;
            error_ts_q      <= error_ts_d;
`endif
        end
    end

    assign bus.fifo_ready      = pop;
    assign bus.evt_valid       = (state_q == S_OFFER);
    assign bus.evt_trig_num    = evt_q.trig_num;
    assign bus.evt_event_cnt   = evt_q.event_cnt;
    assign bus.evt_trig_type   = evt_q.trig_type;
    assign bus.evt_empty       = evt_q.empty;
    assign bus.evt_xadc_alarms = evt_q.xadc;
    assign bus.evt_timestamp   = evt_q.timestamp;

    assign state         = state_q;
    assign events_read   = events_read_q;
    assign empty_events  = empty_events_q;
    assign error_seq     = error_seq_q;
    assign error_format  = error_format_q;
    assign error_timeout = error_timeout_q;
`ifdef TRIG_TIMESTAMP_CHECK_EN
    assign error_timestamp = error_ts_q;
`endif

endmodule

// File: tb/tb_ttc_trigger_info_reader.sv
// Scoreboard bench for ttc_trigger_info_reader: FIFO model feeds words, the
// expected descriptor queue is checked on every accepted offer.
module tb_ttc_trigger_info_reader;
    import ttc_trig_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reset_trig_num = 1'b0;
    logic [2:0]  state;
    logic [23:0] events_read;
    logic [23:0] empty_events;
    logic        error_seq;
    logic        error_format;
    logic        error_timeout;
`ifdef TRIG_TIMESTAMP_CHECK_EN
    logic        error_timestamp;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [127:0] fifo_q[$];
    trig_info_t   exp_q[$];
    logic         pop_pending = 1'b0;

    ttc_trigger_info_reader_if bus();

    ttc_trigger_info_reader #(.DONE_TIMEOUT(24'd16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .reset_trig_num (reset_trig_num),
        .bus            (bus),
        .state          (state),
        .events_read    (events_read),
        .empty_events   (empty_events),
        .error_seq      (error_seq),
        .error_format   (error_format),
        .error_timeout  (error_timeout)
`ifdef TRIG_TIMESTAMP_CHECK_EN
        ,
        .error_timestamp(error_timestamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_valid = (fifo_q.size() > 0);
        bus.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 128'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [23:0] trig, input logic [23:0] cnt,
                             input logic [4:0] typ, input logic empty,
                             input logic [3:0] xadc, input logic [43:0] ts,
                             input logic [25:0] rsvd);
        trig_info_t e;
        fifo_q.push_back({rsvd, xadc, empty, typ, cnt, trig, ts});
        e.trig_num  = trig;
        e.event_cnt = cnt;
        e.trig_type = typ;
        e.empty     = empty;
        e.xadc      = xadc;
        e.timestamp = ts;
        exp_q.push_back(e);
        drive_fifo();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int bound);
        int n = 0;
        while (state !== target && n < bound) begin
            tick();
            n++;
        end
        check(tag, 64'(state), 64'(target));
    endtask

    task automatic process_event(input string tag);
        wait_state({tag, "_wait"}, 3'b100, 20);
        bus.readout_done = 1'b1;
        tick();
        bus.readout_done = 1'b0;
        check({tag, "_idle"}, 64'(state), 64'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // FIFO model: a pop seen at the falling edge takes effect at the next rising edge.
    always @(negedge clk) begin
        pop_pending = bus.fifo_ready;
        if (bus.fifo_ready) check("pop_only_in_idle", 64'(state), 64'd1);
        if (bus.evt_valid && bus.evt_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
                trig_info_t e;
                e = exp_q.pop_front();
                check("evt_trig_num",  64'(bus.evt_trig_num),    64'(e.trig_num));
                check("evt_event_cnt", 64'(bus.evt_event_cnt),   64'(e.event_cnt));
                check("evt_trig_type", 64'(bus.evt_trig_type),   64'(e.trig_type));
                check("evt_empty",     64'(bus.evt_empty),       64'(e.empty));
                check("evt_xadc",      64'(bus.evt_xadc_alarms), 64'(e.xadc));
                check("evt_timestamp", 64'(bus.evt_timestamp),   64'(e.timestamp));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
        pop_pending = 1'b0;
        drive_fifo();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.fifo_valid   = 1'b0;
        bus.fifo_data    = 128'd0;
        bus.evt_ready    = 1'b1;
        bus.readout_done = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_state",        64'(state),          64'd1);
        check("rst_evt_valid",    64'(bus.evt_valid),  64'd0);
        check("rst_fifo_ready",   64'(bus.fifo_ready), 64'd0);
        check("rst_events_read",  64'(events_read),    64'd0);
        check("rst_empty_events", 64'(empty_events),   64'd0);
        check("rst_errors", 64'({error_seq, error_format, error_timeout}), 64'd0);
        check("rst_evt_trig_num", 64'(bus.evt_trig_num), 64'd0);
        reset_n = 1'b1;
        tick();

        // Three in-sequence events
        for (int i = 1; i <= 3; i++) begin
            push_word(24'(i), 24'(i), (i == 2) ? 5'b00111 : 5'(i), 1'b0,
                      4'(i), 44'(1000 * i) + 44'h800_0000_0000, 26'd0);
            process_event("seq");
        end
        check("seq_events_read", 64'(events_read), 64'd3);
        check("seq_err_seq",     64'(error_seq),   64'd0);
        check("seq_err_fmt",     64'(error_format), 64'd0);
        check("seq_err_to",      64'(error_timeout), 64'd0);
        check("seq_sb_drain",    64'(exp_q.size()), 64'd0);

        // Trigger-number gap, then resync
        push_word(24'd5, 24'd4, 5'd1, 1'b0, 4'd0, 44'd5000, 26'd0);
        process_event("gap");
        check("gap_err_seq", 64'(error_seq), 64'd1);
        push_word(24'd6, 24'd5, 5'd1, 1'b0, 4'd0, 44'd6000, 26'd0);
        process_event("resync");
        check("resync_events_read", 64'(events_read), 64'd5);

        // Empty event does not disturb event-count continuity
        do_reset();
        check("rst2_err_seq", 64'(error_seq), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            push_word(24'(i), 24'(i), 5'd2, 1'b0, 4'hF, 44'(10 * i), 26'd0);
            process_event("pre_empty");
        end
        push_word(24'd4, 24'd9, 5'd3, 1'b1, 4'd0, 44'd40, 26'd0);
        process_event("empty");
        push_word(24'd5, 24'd4, 5'd3, 1'b0, 4'd0, 44'd50, 26'd0);
        process_event("after_empty");
        check("empty_err_seq",      64'(error_seq),    64'd0);
        check("empty_empty_events", 64'(empty_events), 64'd1);
        check("empty_events_read",  64'(events_read),  64'd5);

        // reset_trig_num alone, then coincident with a pop
        reset_trig_num = 1'b1;
        tick();
        reset_trig_num = 1'b0;
        push_word(24'd1, 24'd1, 5'd4, 1'b0, 4'd1, 44'd60, 26'd0);
        process_event("rtn");
        check("rtn_err_seq", 64'(error_seq), 64'd0);
        push_word(24'd50, 24'd50, 5'd4, 1'b0, 4'd2, 44'd70, 26'd0);
        reset_trig_num = 1'b1;
        tick();
        reset_trig_num = 1'b0;
        process_event("rtn_pop");
        push_word(24'd1, 24'd1, 5'd4, 1'b0, 4'd3, 44'd80, 26'd0);
        process_event("rtn_after");
        check("rtn_pop_err_seq", 64'(error_seq), 64'd0);
        check("rtn_events_read", 64'(events_read), 64'd8);

        // Reserved bit 120 set: format error, event still offered
        do_reset();
        push_word(24'd1, 24'd1, 5'd5, 1'b0, 4'd0, 44'd90, 26'd1 << 18);
        process_event("fmt");
        check("fmt_err_fmt", 64'(error_format), 64'd1);
        check("fmt_err_seq", 64'(error_seq),    64'd0);
        check("fmt_sb",      64'(exp_q.size()), 64'd0);

        // readout_done never arrives: timeout after 16 WAIT_DONE cycles
        push_word(24'd2, 24'd2, 5'd6, 1'b0, 4'd0, 44'd100, 26'd0);
        wait_state("to_wait", 3'b100, 20);
        n = 0;
        while (state == 3'b100 && n < 40) begin
            n++;
            tick();
        end
        check("to_cycles",   64'(n),             64'd16);
        check("to_err",      64'(error_timeout), 64'd1);
        check("to_state",    64'(state),         64'd1);
        push_word(24'd3, 24'd3, 5'd6, 1'b0, 4'd0, 44'd110, 26'd0);
        process_event("after_to");
        check("to_events_read", 64'(events_read), 64'd3);
        check("to_err_seq",     64'(error_seq),   64'd0);

        // Reset while an event is being offered
        bus.evt_ready = 1'b0;
        push_word(24'd4, 24'd4, 5'd7, 1'b0, 4'd0, 44'd120, 26'd0);
        wait_state("offer_wait", 3'b010, 10);
        check("offer_valid", 64'(bus.evt_valid), 64'd1);
        do_reset();
        check("abort_state",        64'(state),          64'd1);
        check("abort_evt_valid",    64'(bus.evt_valid),  64'd0);
        check("abort_fifo_ready",   64'(bus.fifo_ready), 64'd0);
        check("abort_events_read",  64'(events_read),    64'd0);
        check("abort_empty_events", 64'(empty_events),   64'd0);
        check("abort_errors", 64'({error_seq, error_format, error_timeout}), 64'd0);
        check("abort_sb", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) exp_q.delete(0);
        bus.evt_ready = 1'b1;
        push_word(24'd1, 24'd1, 5'd7, 1'b0, 4'd0, 44'd130, 26'd0);
        process_event("post_abort");
        check("post_abort_events_read", 64'(events_read), 64'd1);
        check("post_abort_err_seq",     64'(error_seq),   64'd0);
        check("final_sb", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
